inv_sub_bytes_iter: RTL

- Iterative InvSubBytes unit for the AES-128 decryption datapath; the inverse of the existing forward S-box substitution.
- Accepts one 128-bit state word over a valid/ready handshake and substitutes LANES bytes per cycle through LANES inverse S-box instances.
- Presents the 128-bit result over a valid/ready handshake to the InvShiftRows/AddRoundKey stage of the decryption round.

---
 rtl/inv_sub_bytes_iter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_iter
//   Iterative AES InvSubBytes unit for the decryption round. A 128-bit state
//   word is accepted over a valid/ready handshake and LANES bytes are passed
//   through the FIPS-197 inverse S-box per cycle. After G = 16/LANES cycles the
//   result is offered downstream (InvShiftRows/AddRoundKey) over valid/ready.
//
// Handshake rule (both sides): a transfer happens on a rising edge where valid
//   and ready are both high. The sender keeps valid and data stable until that
//   edge; ready is not allowed to depend on valid.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset (aborts any word in flight)
//   i_valid  : input state word valid
//   o_ready  : unit can accept a word (high only in IDLE)
//   i_state  : input state, byte 0 = [127:120] ... byte 15 = [7:0]
//   o_valid  : o_state holds a completed result (DONE)
//   i_ready  : downstream accepts the result
//   o_state  : substituted state, same byte order as i_state
//   o_busy   : high in RUN or DONE
// -----------------------------------------------------------------------------
module inv_sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [127:0] i_state,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [127:0] o_state,
   output logic         o_busy
);

   localparam int G  = 16 / LANES;
   localparam int CW = (G > 1) ? $clog2(G) : 1;
   localparam int GW = LANES * 8;
   localparam logic [CW-1:0] LAST_GRP = CW'(G - 1);

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
         $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   // FIPS-197 inverse S-box, indexed by the input byte.
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state, w_next_state;
   logic [CW-1:0]   r_cnt, w_next_cnt;
   logic [127:0]    r_work, w_next_work, w_sub_work;
   logic [GW-1:0]   w_grp_in, w_grp_out;

   // Group cnt occupies bytes cnt*LANES .. cnt*LANES+LANES-1, i.e. byte 0 is
   // the most significant byte of the word.
   assign w_grp_in = r_work[127 - int'(r_cnt) * GW -: GW];

   // One inverse S-box lookup per lane.
   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign w_grp_out[GW-1-8*l -: 8] = INV_SBOX[w_grp_in[GW-1-8*l -: 8]];
      end
   endgenerate

   always_comb begin
      w_sub_work = r_work;
      w_sub_work[127 - int'(r_cnt) * GW -: GW] = w_grp_out;
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_next_work  = r_work;
      case (r_state)
         S_IDLE: begin
            if (i_valid) begin
               w_next_work  = i_state;
               w_next_cnt   = '0;
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            w_next_work = w_sub_work;
            if (r_cnt == LAST_GRP) begin
               w_next_cnt   = '0;
               w_next_state = S_DONE;
            end else begin
               w_next_cnt = r_cnt + 1'b1;
            end
         end
         S_DONE: begin
            if (i_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_work  <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         r_work  <= w_next_work;
      end
   end

   assign o_ready = (r_state == S_IDLE);
   assign o_valid = (r_state == S_DONE);
   assign o_busy  = (r_state == S_RUN) || (r_state == S_DONE);
   assign o_state = r_work;

endmodule
